alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX pipeline stage that sits directly upstream of the ALU and drives its A, B and 4-bit ALUCtrl inputs.
- Decodes RISC-V ALUOp/funct fields into ALUCtrl: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT.
- Resolves operand forwarding from the MEM and WB stages and selects immediate vs register for B.
- Registers the result behind a valid/ready handshake, with support for stall and flush.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of the stage contents.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept this cycle.
- alu_op  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
- funct3  in  3  instruction funct3.
- funct7_5  in  1  instruction bit 30.
- rs1_addr, rs2_addr, rd_addr  in  RA_W  register addresses.
- rs1_data, rs2_data  in  XLEN  register-file read data.
- imm  in  XLEN  sign-extended immediate.
- use_imm  in  1  B = imm when 1.
- reg_write  in  1  instruction writes rd.
- fwd_mem_we, fwd_wb_we  in  1  forwarding-source write enables.
- fwd_mem_rd, fwd_wb_rd  in  RA_W  forwarding-source destinations.
- fwd_mem_data, fwd_wb_data  in  XLEN  forwarding-source values.
- out_valid  out  1  registered outputs hold a live instruction.
- out_ready  in  1  ALU/EX consumer accepts.
- A, B  out  XLEN  ALU operands.
- ALUCtrl  out  4  ALU function.
- store_data  out  XLEN  forwarded rs2 value, independent of use_imm.
- out_rd  out  RA_W  destination register.
- out_reg_write  out  1  gated write enable.
- out_illegal  out  1  unsupported funct combination.

Behaviour:
- Reset (async, rst=1): all outputs 0, including out_valid, A, B, ALUCtrl, out_rd, out_reg_write and out_illegal.
- Handshake: in_ready = (!out_valid | out_ready) & !flush, combinational.
  - A transfer occurs when in_valid & in_ready.
  - On the next edge all output registers load and out_valid becomes 1.
  - Latency is one cycle.
- Drain: if out_valid & out_ready with no transfer, out_valid becomes 0 at the next edge. Data registers keep their stale values.
- Stall: while out_valid & !out_ready, every output holds bit-stable. in_ready = 0.
- Flush: has priority over everything else.
  - At the next edge out_valid = 0 and out_reg_write = 0.
  - A concurrent in_valid is not accepted, because in_ready = 0.
- Back-to-back: out_valid & out_ready & in_valid gives a new transfer on that edge, with no bubble.
- Forwarding (per source operand rs1 or rs2, sampled at the transfer cycle):
  - Address 0 is never forwarded; the register-file value is used.
  - Else if fwd_mem_we and fwd_mem_rd matches, use fwd_mem_data (MEM has priority).
  - Else if fwd_wb_we and fwd_wb_rd matches, use fwd_wb_data.
  - Else use the register-file data.
- Operand select: A = fwd rs1; B = use_imm ? imm : fwd rs2; store_data = fwd rs2.
- Decode:
  - alu_op 00 gives 0010.
  - alu_op 01 gives 0110.
  - alu_op 10, by funct3: 000 gives 0010 if funct7_5=0, else 0110; 111 gives 0000; 110 gives 0001; 010 gives 0111.
  - alu_op 11, by funct3 (funct7_5 ignored): 000 gives 0010; 111 gives 0000; 110 gives 0001; 010 gives 0111.
  - Any other funct3: ALUCtrl = 0010, out_illegal = 1, out_reg_write = 0.
- Write gating: out_reg_write = reg_write & !illegal & (rd_addr != 0).
- Reset mid-stall: outputs clear immediately. The held instruction is lost, and in_ready returns to 1 after rst falls.

Test Plan:
- Reset then R-type ADD: alu_op=10, funct3=000, funct7_5=0, rs1_data=0x10000000, rs2_data=0x00001000, no forwarding.
  - Next edge: out_valid=1, A=0x10000000, B=0x00001000, ALUCtrl=0010.
- Decode sweep, one instruction each with out_ready=1:
  - R SUB gives 0110; AND 0000; OR 0001; SLT 0111.
  - I-type 000 with funct7_5=1 gives 0010.
  - alu_op=01 gives 0110.
  - funct3=001 gives out_illegal=1, ALUCtrl=0010, out_reg_write=0.
- Forwarding: rs1=rs2=5; mem rd=5 data=0xAAAA0000 we=1; wb rd=5 data=0x5555 we=1.
  - Result: A=B=0xAAAA0000.
  - Repeat with mem we=0: A=B=0x00005555.
  - Repeat with rs1=0: A=rs1_data.
- Stall: hold out_ready=0 for 3 cycles with in_valid=1 and changing inputs.
  - Outputs stay constant and in_ready=0.
  - When out_ready=1, the next instruction loads on that edge.
- Flush with out_valid=1 and in_valid=1: next edge out_valid=0 and the input is not consumed (in_ready=0 that cycle).
- Async reset asserted mid-stall between clock edges: outputs go 0 immediately, without waiting for clk.

Source files
------------

// File: rtl/alu_issue_stage.sv
// ID/EX stage in front of the ALU: decodes ALUCtrl, resolves MEM/WB forwarding,
// picks the B operand and registers the result behind a valid/ready handshake.
module alu_issue_stage #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic [RA_W-1:0] rs1_addr,
  input  logic [RA_W-1:0] rs2_addr,
  input  logic [RA_W-1:0] rd_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  input  logic            reg_write,
  input  logic            fwd_mem_we,
  input  logic            fwd_wb_we,
  input  logic [RA_W-1:0] fwd_mem_rd,
  input  logic [RA_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] A,
  output logic [XLEN-1:0] B,
  output logic [3:0]      ALUCtrl,
  output logic [XLEN-1:0] store_data,
  output logic [RA_W-1:0] out_rd,
  output logic            out_reg_write,
  output logic            out_illegal
);
  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_SLT = 4'b0111;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] sd;
    logic [3:0]      ctrl;
    logic [RA_W-1:0] rd;
    logic            rw;
    logic            ill;
  } res_t;

  res_t            res_d, res_q;
  logic            vld_q;
  logic            xfer;
  logic [XLEN-1:0] op1, op2;
  logic [3:0]      ctrl;
  logic            ill;

  // MEM wins over WB; x0 is hardwired and never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RA_W-1:0] addr,   input logic [XLEN-1:0] rf,
    input logic            mem_we, input logic [RA_W-1:0] mem_rd, input logic [XLEN-1:0] mem_d,
    input logic            wb_we,  input logic [RA_W-1:0] wb_rd,  input logic [XLEN-1:0] wb_d);
    if (addr == '0)                        return rf;
    else if (mem_we && (mem_rd == addr))   return mem_d;
    else if (wb_we && (wb_rd == addr))     return wb_d;
    else                                   return rf;
  endfunction

  assign op1 = fwd_sel(rs1_addr, rs1_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                       fwd_wb_we, fwd_wb_rd, fwd_wb_data);
  assign op2 = fwd_sel(rs2_addr, rs2_data, fwd_mem_we, fwd_mem_rd, fwd_mem_data,
                       fwd_wb_we, fwd_wb_rd, fwd_wb_data);

  always_comb begin
    ctrl = CTRL_ADD;
    ill  = 1'b0;
    case (alu_op)
      2'b00: ctrl = CTRL_ADD;
      2'b01: ctrl = CTRL_SUB;
      default: begin
        // funct7_5 only selects SUB for R-type; I-type has no SUBI.
        case (funct3)
          3'b000:  ctrl = ((alu_op == 2'b10) && funct7_5) ? CTRL_SUB : CTRL_ADD;
          3'b111:  ctrl = CTRL_AND;
          3'b110:  ctrl = CTRL_OR;
          3'b010:  ctrl = CTRL_SLT;
          default: ill  = 1'b1;
        endcase
      end
    endcase
  end

  always_comb begin
    res_d.a    = op1;
    res_d.b    = use_imm ? imm : op2;
    res_d.sd   = op2;
    res_d.ctrl = ctrl;
    res_d.rd   = rd_addr;
    res_d.rw   = reg_write & ~ill & (rd_addr != '0);
    res_d.ill  = ill;
  end

  assign in_ready = (~vld_q | out_ready) & ~flush;
  assign xfer     = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= 1'b0;
      res_q <= '0;
    end else if (flush) begin
      vld_q    <= 1'b0;
      res_q.rw <= 1'b0;
    end else if (xfer) begin
      vld_q <= 1'b1;
      res_q <= res_d;
    end else if (out_ready) begin
      vld_q <= 1'b0;
    end
  end

  assign out_valid     = vld_q;
  assign A             = res_q.a;
  assign B             = res_q.b;
  assign store_data    = res_q.sd;
  assign ALUCtrl       = res_q.ctrl;
  assign out_rd        = res_q.rd;
  assign out_reg_write = res_q.rw;
  assign out_illegal   = res_q.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode, forwarding, stall, flush, async reset.
module tb_alu_issue_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  alu_op = '0;
  logic [2:0]  funct3 = '0;
  logic        funct7_5 = 1'b0;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0, rd_addr = '0;
  logic [31:0] rs1_data = '0, rs2_data = '0, imm = '0;
  logic        use_imm = 1'b0, reg_write = 1'b0;
  logic        fwd_mem_we = 1'b0, fwd_wb_we = 1'b0;
  logic [4:0]  fwd_mem_rd = '0, fwd_wb_rd = '0;
  logic [31:0] fwd_mem_data = '0, fwd_wb_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] A, B, store_data;
  logic [3:0]  ALUCtrl;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_illegal;

  int total = 0;
  int bad   = 0;

  alu_issue_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .use_imm(use_imm),
    .reg_write(reg_write), .fwd_mem_we(fwd_mem_we), .fwd_wb_we(fwd_wb_we),
    .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B), .ALUCtrl(ALUCtrl),
    .store_data(store_data), .out_rd(out_rd), .out_reg_write(out_reg_write),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One decode-sweep instruction, accepted back-to-back.
  task automatic issue(input string tag, input logic [1:0] op, input logic [2:0] f3,
                       input logic f75, input logic [4:0] rd,
                       input logic [3:0] exp_ctrl, input logic exp_ill, input logic exp_rw);
    alu_op = op; funct3 = f3; funct7_5 = f75; rd_addr = rd; reg_write = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_ctrl"}, {28'd0, ALUCtrl}, {28'd0, exp_ctrl});
    chk({tag, "_ill"}, {31'd0, out_illegal}, {31'd0, exp_ill});
    chk({tag, "_rw"}, {31'd0, out_reg_write}, {31'd0, exp_rw});
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_async_vld", {31'd0, out_valid}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    chk("rst_ctrl", {28'd0, ALUCtrl}, 32'd0);
    chk("rst_rw", {31'd0, out_reg_write}, 32'd0);
    chk("rst_ill", {31'd0, out_illegal}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // R-type ADD, no forwarding
    alu_op = 2'b10; funct3 = 3'b000; funct7_5 = 1'b0;
    rs1_addr = 5'd1; rs2_addr = 5'd2; rd_addr = 5'd3; reg_write = 1'b1;
    rs1_data = 32'h1000_0000; rs2_data = 32'h0000_1000;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    chk("add_vld", {31'd0, out_valid}, 32'd1);
    chk("add_A", A, 32'h1000_0000);
    chk("add_B", B, 32'h0000_1000);
    chk("add_ctrl", {28'd0, ALUCtrl}, 32'h2);
    chk("add_rd", {27'd0, out_rd}, 32'd3);
    chk("add_rw", {31'd0, out_reg_write}, 32'd1);

    issue("sub",   2'b10, 3'b000, 1'b1, 5'd3, 4'b0110, 1'b0, 1'b1);
    issue("and",   2'b10, 3'b111, 1'b0, 5'd3, 4'b0000, 1'b0, 1'b1);
    issue("or",    2'b10, 3'b110, 1'b0, 5'd3, 4'b0001, 1'b0, 1'b1);
    issue("slt",   2'b10, 3'b010, 1'b0, 5'd3, 4'b0111, 1'b0, 1'b1);
    issue("addi",  2'b11, 3'b000, 1'b1, 5'd3, 4'b0010, 1'b0, 1'b1);
    issue("br",    2'b01, 3'b000, 1'b0, 5'd3, 4'b0110, 1'b0, 1'b1);
    issue("ld",    2'b00, 3'b101, 1'b1, 5'd3, 4'b0010, 1'b0, 1'b1);
    issue("ill_r", 2'b10, 3'b001, 1'b0, 5'd3, 4'b0010, 1'b1, 1'b0);
    issue("ill_i", 2'b11, 3'b101, 1'b0, 5'd3, 4'b0010, 1'b1, 1'b0);
    issue("rd0",   2'b10, 3'b000, 1'b0, 5'd0, 4'b0010, 1'b0, 1'b0);

    // Forwarding: MEM beats WB on both operands
    alu_op = 2'b10; funct3 = 3'b000; funct7_5 = 1'b0; rd_addr = 5'd7;
    rs1_addr = 5'd5; rs2_addr = 5'd5;
    rs1_data = 32'h1111_1111; rs2_data = 32'h2222_2222;
    fwd_mem_we = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'hAAAA_0000;
    fwd_wb_we  = 1'b1; fwd_wb_rd  = 5'd5; fwd_wb_data  = 32'h0000_5555;
    step();
    chk("fwd_mem_A", A, 32'hAAAA_0000);
    chk("fwd_mem_B", B, 32'hAAAA_0000);
    fwd_mem_we = 1'b0;
    step();
    chk("fwd_wb_A", A, 32'h0000_5555);
    chk("fwd_wb_B", B, 32'h0000_5555);
    rs1_addr = 5'd0;
    step();
    chk("fwd_x0_A", A, 32'h1111_1111);
    chk("fwd_x0_B", B, 32'h0000_5555);
    use_imm = 1'b1; imm = 32'hFFFF_FFF0; fwd_wb_we = 1'b0;
    step();
    chk("imm_B", B, 32'hFFFF_FFF0);
    chk("imm_sd", store_data, 32'h2222_2222);
    chk("imm_A", A, 32'h1111_1111);

    // Stall: held instruction A=1111_1111 B=FFFF_FFF0 ADD
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rs1_data = 32'h3000_0000 + i; imm = 32'h0000_0100 + i; funct3 = 3'b111;
      #1;
      chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      chk("stall_vld", {31'd0, out_valid}, 32'd1);
      chk("stall_A", A, 32'h1111_1111);
      chk("stall_B", B, 32'hFFFF_FFF0);
      chk("stall_ctrl", {28'd0, ALUCtrl}, 32'h2);
    end
    rs1_data = 32'h4444_4444; imm = 32'h0000_0042; funct3 = 3'b110;
    out_ready = 1'b1;
    #1;
    chk("unstall_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("unstall_A", A, 32'h4444_4444);
    chk("unstall_B", B, 32'h0000_0042);
    chk("unstall_ctrl", {28'd0, ALUCtrl}, 32'h1);

    // Flush with a concurrent valid input
    rs1_data = 32'h5555_AAAA; flush = 1'b1;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_vld", {31'd0, out_valid}, 32'd0);
    chk("flush_rw", {31'd0, out_reg_write}, 32'd0);
    chk("flush_A_not_taken", A, 32'h4444_4444);
    step();
    chk("flush_idle_vld", {31'd0, out_valid}, 32'd0);

    // Drain after a single transfer
    in_valid = 1'b1; rs1_data = 32'h0000_0077;
    step();
    in_valid = 1'b0;
    chk("drain_load_vld", {31'd0, out_valid}, 32'd1);
    step();
    chk("drain_vld", {31'd0, out_valid}, 32'd0);
    chk("drain_A_stale", A, 32'h0000_0077);

    // Async reset mid-stall
    in_valid = 1'b1; rs1_data = 32'h0000_0099;
    step();
    out_ready = 1'b0;
    step();
    chk("pre_rst_vld", {31'd0, out_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_vld", {31'd0, out_valid}, 32'd0);
    chk("midrst_A", A, 32'd0);
    chk("midrst_B", B, 32'd0);
    chk("midrst_ctrl", {28'd0, ALUCtrl}, 32'd0);
    step();
    rst = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_vld", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
